// File: rtl/echo_delay_proc.sv
// Delay-line echo processor: offset-binary samples are mixed with an attenuated
// copy from a circular RAM buffer (bypass / feed-forward / feedback / mute).
module echo_delay_proc #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 13
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] delay,
    input  logic [2:0]        atten,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [DATA_W-1:0] MID     = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    localparam logic [1:0] MODE_BYPASS   = 2'b00;
    localparam logic [1:0] MODE_FFWD     = 2'b01;
    localparam logic [1:0] MODE_FEEDBACK = 2'b10;
    localparam logic [1:0] MODE_MUTE     = 2'b11;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_RD,
        S_WT,
        S_CALC
    } state_t;

    state_t                    state_reg;
    logic [ADDR_W-1:0]         clr_addr_reg;
    logic [ADDR_W-1:0]         wr_ptr_reg;
    logic signed [DATA_W-1:0]  x_reg;
    logic signed [DATA_W-1:0]  d_reg;
    logic [1:0]                mode_reg;
    logic [ADDR_W-1:0]         delay_reg;
    logic [2:0]                atten_reg;
    logic [DATA_W-1:0]         data_out_reg;
    logic                      out_valid_reg;
    logic                      busy_reg;
    logic                      overrun_reg;

    // Single-port buffer: one address shared by the clear, read and write phases.
    logic [DATA_W-1:0]         mem [DEPTH];
    logic [DATA_W-1:0]         ram_rdata_reg;
    logic [ADDR_W-1:0]         ram_addr;
    logic                      ram_we;
    logic [DATA_W-1:0]         ram_wdata;

    logic signed [DATA_W-1:0]  shift_stage [4];
    logic signed [DATA_W:0]    sum;
    logic [DATA_W-1:0]         sat_value;
    logic [DATA_W-1:0]         y_value;

    // Barrel shifter: each stage conditionally applies a 1, 2 or 4 bit arithmetic shift.
    assign shift_stage[0] = d_reg;
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_shift
            assign shift_stage[gi+1] = atten_reg[gi] ? (shift_stage[gi] >>> (2**gi))
                                                     : shift_stage[gi];
        end
    endgenerate

    assign sum = {x_reg[DATA_W-1], x_reg} + {shift_stage[3][DATA_W-1], shift_stage[3]};

    // Overflow shows up as disagreement between the two top bits of the wide sum.
    always_comb begin
        sat_value = sum[DATA_W-1:0];
        if (sum[DATA_W] != sum[DATA_W-1]) begin
            sat_value = sum[DATA_W] ? SAT_MIN : SAT_MAX;
        end
    end

    always_comb begin
        y_value = x_reg;
        case (mode_reg)
            MODE_BYPASS:   y_value = x_reg;
            MODE_FFWD:     y_value = sat_value;
            MODE_FEEDBACK: y_value = sat_value;
            MODE_MUTE:     y_value = '0;
            default:       y_value = x_reg;
        endcase
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = wr_ptr_reg - delay_reg;
        ram_wdata = '0;
        case (state_reg)
            S_CLEAR: begin
                ram_we   = rst_n;
                ram_addr = clr_addr_reg;
            end
            S_CALC: begin
                ram_we    = rst_n;
                ram_addr  = wr_ptr_reg;
                ram_wdata = (mode_reg == MODE_FEEDBACK) ? y_value : x_reg;
            end
            default: begin
                ram_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata_reg <= mem[ram_addr];
    end

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            state_reg     <= S_CLEAR;
            clr_addr_reg  <= '0;
            wr_ptr_reg    <= '0;
            x_reg         <= '0;
            d_reg         <= '0;
            mode_reg      <= MODE_BYPASS;
            delay_reg     <= '0;
            atten_reg     <= '0;
            data_out_reg  <= MID;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b1;
            overrun_reg   <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            if (data_valid && (state_reg != S_IDLE)) begin
                overrun_reg <= 1'b1;
            end
            case (state_reg)
                S_CLEAR: begin
                    clr_addr_reg <= clr_addr_reg + 1'b1;
                    if (&clr_addr_reg) begin
                        state_reg  <= S_IDLE;
                        wr_ptr_reg <= '0;
                        busy_reg   <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (data_valid) begin
                        x_reg     <= data_in ^ MID;
                        mode_reg  <= mode;
                        delay_reg <= delay;
                        atten_reg <= atten;
                        busy_reg  <= 1'b1;
                        state_reg <= S_RD;
                    end
                end
                S_RD: begin
                    state_reg <= S_WT;
                end
                S_WT: begin
                    d_reg     <= (delay_reg == '0) ? '0 : ram_rdata_reg;
                    state_reg <= S_CALC;
                end
                S_CALC: begin
                    data_out_reg  <= y_value ^ MID;
                    out_valid_reg <= 1'b1;
                    wr_ptr_reg    <= wr_ptr_reg + 1'b1;
                    busy_reg      <= 1'b0;
                    state_reg     <= S_IDLE;
                end
                default: begin
                    state_reg <= S_CLEAR;
                end
            endcase
        end
    end

    assign data_out  = data_out_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_echo_delay_proc.sv
// Directed bench for echo_delay_proc with a 16-entry buffer: vector table for the
// steady-state processing modes plus hand sequences for reset and overrun.
module tb_echo_delay_proc;

    logic       sysclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       data_valid = 1'b0;
    logic [9:0] data_in = 10'd512;
    logic [3:0] delay = 4'd0;
    logic [2:0] atten = 3'd0;
    logic [1:0] mode = 2'b00;
    logic [9:0] data_out;
    logic       out_valid;
    logic       busy;
    logic       overrun;

    int checks = 0;
    int failures = 0;

    echo_delay_proc #(.DATA_W(10), .ADDR_W(4)) dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .data_valid (data_valid),
        .data_in    (data_in),
        .delay      (delay),
        .atten      (atten),
        .mode       (mode),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        logic [9:0] din;
        logic [3:0] dly;
        logic [2:0] att;
        logic [1:0] md;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [9:0] din, input logic [3:0] dly,
                                input logic [2:0] att, input logic [1:0] md,
                                input logic [9:0] exp);
        vec_t v;
        v.din = din; v.dly = dly; v.att = att; v.md = md; v.exp = exp;
        vecs.push_back(v);
    endfunction

    // Sixteen bypass mid-scale samples overwrite the whole buffer with zeros.
    function automatic void add_flush();
        for (int i = 0; i < 16; i++) add(10'd512, 4'd0, 3'd0, 2'b00, 10'd512);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_sample(input int idx, input vec_t v);
        @(negedge sysclk);
        chk("idle_no_valid", out_valid, 0);
        data_in = v.din; delay = v.dly; atten = v.att; mode = v.md;
        data_valid = 1'b1;
        @(negedge sysclk);
        data_valid = 1'b0;
        data_in = ~v.din; delay = ~v.dly; atten = ~v.att; mode = ~v.md;
        chk("busy_after_accept", busy, 1);
        @(negedge sysclk);
        @(negedge sysclk);
        chk("no_early_valid", out_valid, 0);
        @(negedge sysclk);
        chk("out_valid_n3", out_valid, 1);
        chk("data_out", data_out, v.exp);
        chk("busy_done", busy, 0);
        $display("sample %0d: din=%0d mode=%0d delay=%0d atten=%0d out=%0d exp=%0d",
                 idx, v.din, v.md, v.dly, v.att, data_out, v.exp);
    endtask

    // Called right after rst_n is released on a falling edge.
    task automatic clear_check();
        for (int i = 0; i < 15; i++) begin
            @(negedge sysclk);
            chk("clear_busy", busy, 1);
            chk("clear_no_valid", out_valid, 0);
            chk("clear_data_out", data_out, 512);
        end
        @(negedge sysclk);
        chk("clear_done_busy", busy, 0);
        $display("clear complete: busy=%0d overrun=%0d", busy, overrun);
    endtask

    initial begin
        int pulses;

        // Reset / clear, then feed-forward over a zeroed buffer.
        for (int i = 0; i < 20; i++) add(10'd512, 4'd5, 3'd0, 2'b01, 10'd512);
        // Bypass ignores atten/delay; mute forces mid-scale.
        add(10'd700, 4'd0,  3'd0, 2'b00, 10'd700);
        add(10'd700, 4'd15, 3'd7, 2'b00, 10'd700);
        add(10'd700, 4'd5,  3'd3, 2'b00, 10'd700);
        add(10'd700, 4'd1,  3'd0, 2'b11, 10'd512);
        add_flush();
        // Feed-forward single echo, delay 3, atten 1.
        add(10'd1023, 4'd3, 3'd1, 2'b01, 10'd1023);
        add(10'd512,  4'd3, 3'd1, 2'b01, 10'd512);
        add(10'd512,  4'd3, 3'd1, 2'b01, 10'd512);
        add(10'd512,  4'd3, 3'd1, 2'b01, 10'd767);
        for (int i = 0; i < 4; i++) add(10'd512, 4'd3, 3'd1, 2'b01, 10'd512);
        add_flush();
        // Feedback decaying echoes, delay 2, atten 1.
        add(10'd1023, 4'd2, 3'd1, 2'b10, 10'd1023);
        add(10'd512,  4'd2, 3'd1, 2'b10, 10'd512);
        add(10'd512,  4'd2, 3'd1, 2'b10, 10'd767);
        add(10'd512,  4'd2, 3'd1, 2'b10, 10'd512);
        add(10'd512,  4'd2, 3'd1, 2'b10, 10'd639);
        add(10'd512,  4'd2, 3'd1, 2'b10, 10'd512);
        add(10'd512,  4'd2, 3'd1, 2'b10, 10'd575);
        add(10'd512,  4'd2, 3'd1, 2'b10, 10'd512);
        add(10'd512,  4'd2, 3'd1, 2'b10, 10'd543);
        add_flush();
        // Saturation at both rails, then a negative echo through the shifter.
        add(10'd1023, 4'd1, 3'd0, 2'b01, 10'd1023);
        for (int i = 0; i < 3; i++) add(10'd1023, 4'd1, 3'd0, 2'b01, 10'd1023);
        add(10'd0, 4'd1, 3'd0, 2'b01, 10'd511);
        for (int i = 0; i < 3; i++) add(10'd0, 4'd1, 3'd0, 2'b01, 10'd0);
        add(10'd256, 4'd1, 3'd2, 2'b01, 10'd128);
        add(10'd256, 4'd1, 3'd2, 2'b01, 10'd192);
        add(10'd256, 4'd1, 3'd2, 2'b01, 10'd192);
        add_flush();
        // Delay 15 across the write-pointer wrap.
        add(10'd612, 4'd15, 3'd0, 2'b01, 10'd612);
        for (int i = 0; i < 14; i++) add(10'd512, 4'd15, 3'd0, 2'b01, 10'd512);
        add(10'd512, 4'd15, 3'd0, 2'b01, 10'd612);
        add(10'd512, 4'd15, 3'd0, 2'b01, 10'd512);

        repeat (3) @(negedge sysclk);
        chk("reset_data_out", data_out, 512);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 1);
        chk("reset_overrun", overrun, 0);
        rst_n = 1'b1;
        clear_check();

        for (int i = 0; i < vecs.size(); i++) do_sample(i, vecs[i]);

        // Overrun: second strobe two cycles into a sample is dropped.
        @(negedge sysclk);
        chk("pre_overrun", overrun, 0);
        data_in = 10'd600; mode = 2'b00; delay = 4'd0; atten = 3'd0; data_valid = 1'b1;
        @(negedge sysclk); data_valid = 1'b0;
        @(negedge sysclk); data_in = 10'd800; data_valid = 1'b1;
        @(negedge sysclk); data_valid = 1'b0;
        chk("ovr_set", overrun, 1);
        chk("ovr_no_early_valid", out_valid, 0);
        @(negedge sysclk);
        chk("ovr_out_valid", out_valid, 1);
        chk("ovr_data_out", data_out, 600);
        pulses = 0;
        repeat (6) begin @(negedge sysclk); if (out_valid) pulses++; end
        chk("ovr_single_pulse", pulses, 0);
        chk("ovr_sticky", overrun, 1);
        $display("overrun N/N+2: data_out=%0d overrun=%0d", data_out, overrun);

        // Reset one edge into a sample: no output, clear restarts, flag cleared.
        @(negedge sysclk);
        data_in = 10'd900; mode = 2'b00; data_valid = 1'b1;
        @(negedge sysclk); data_valid = 1'b0; rst_n = 1'b0;
        @(negedge sysclk);
        chk("rst_mid_no_valid", out_valid, 0);
        chk("rst_mid_busy", busy, 1);
        chk("rst_mid_data_out", data_out, 512);
        chk("rst_mid_overrun", overrun, 0);
        rst_n = 1'b1;
        clear_check();
        chk("post_clear_overrun", overrun, 0);

        // Strobe on the output edge (N+3) is dropped.
        @(negedge sysclk);
        data_in = 10'd600; mode = 2'b00; data_valid = 1'b1;
        @(negedge sysclk); data_valid = 1'b0;
        @(negedge sysclk);
        @(negedge sysclk); data_in = 10'd800; data_valid = 1'b1;
        @(negedge sysclk); data_valid = 1'b0;
        chk("n3_out_valid", out_valid, 1);
        chk("n3_data_out", data_out, 600);
        chk("n3_overrun", overrun, 1);
        pulses = 0;
        repeat (6) begin @(negedge sysclk); if (out_valid) pulses++; end
        chk("n3_dropped", pulses, 0);
        chk("n3_data_hold", data_out, 600);
        $display("overrun N/N+3: data_out=%0d overrun=%0d", data_out, overrun);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/echo_delay_proc.md
# echo_delay_proc

Parametrised delay-line audio processor sitting between the SPI ADC and SPI DAC/PWM interfaces, driven by the per-sample `data_valid` strobe. Each accepted sample is converted from offset-binary to two's complement, combined with an attenuated copy of a sample from `delay` samples earlier held in a circular RAM buffer, saturated, and converted back to offset-binary. Four runtime modes are provided: bypass, single echo (feed-forward), multi-echo (feedback) and mute. The buffer is zero-filled after reset, and samples that arrive while the block is busy set a sticky overrun flag.

## Interface
- `DATA_W`, 10, sample width; offset-binary with mid-scale `2^(DATA_W-1)`.
- `ADDR_W`, 13, buffer address width; depth `2^ADDR_W` samples, single-port synchronous RAM.
- `sysclk`  in  1  system clock (50 MHz).
- `rst_n`  in  1  synchronous active-low reset.
- `data_valid`  in  1  one-cycle strobe: `data_in` is valid.
- `data_in`  in  DATA_W  ADC sample, offset-binary.
- `delay`  in  ADDR_W  echo delay in samples; 0 = no echo term.
- `atten`  in  3  echo attenuation, arithmetic right-shift amount (0..7).
- `mode`  in  2  00 bypass, 01 feed-forward echo, 10 feedback echo, 11 mute.
- `data_out`  out  DATA_W  processed sample, offset-binary; holds between updates.
- `out_valid`  out  1  one-cycle strobe: `data_out` updated.
- `busy`  out  1  high when the block is not in IDLE.
- `overrun`  out  1  sticky: a `data_valid` was dropped; cleared only by reset.

## Operation
- States: CLEAR, IDLE, RD, WT, CALC.
- Reset (`rst_n`=0 at an edge), from any state including mid-sample:
  - state goes to CLEAR; clear address 0; `wr_ptr` 0.
  - `data_out` = mid-scale (512 for DATA_W=10); `out_valid` 0; `overrun` 0; `busy` 1.
- CLEAR: writes 0 to addresses 0 .. `2^ADDR_W - 1`, one per cycle. After the last write it enters IDLE with `wr_ptr` = 0.
- IDLE, on `data_valid`=1:
  - capture `x = data_in ^ (1 << (DATA_W-1))` (signed).
  - capture `mode`, `delay` and `atten`; these captured values are used for the whole sample, so later input changes do not affect it.
  - go to RD.
- RD: present read address `(wr_ptr - delay) mod 2^ADDR_W`; go to WT.
- WT: register RAM output as signed `d`; if the captured `delay` = 0, force `d` = 0. Go to CALC.
- CALC:
  - compute `e = d >>> atten` (arithmetic shift).
  - compute `s = x + e` at DATA_W+1 bits, then saturate to [`-2^(DATA_W-1)`, `2^(DATA_W-1)-1`].
  - result `y` by mode: bypass `y = x`; feed-forward and feedback `y = sat(s)`; mute `y = 0`.
  - RAM write at `wr_ptr`: feedback mode writes `y`; all other modes write `x`.
  - `wr_ptr` increments modulo `2^ADDR_W` (wrap-around is natural).
  - `data_out <= y ^ (1 << (DATA_W-1))`; `out_valid` pulses.
  - go to IDLE.
- `data_valid`=1 in any state other than IDLE (including CLEAR): the sample is dropped, `overrun` is set to 1, and the in-progress state is unaffected.
- RAM contents are undefined only during CLEAR; the echo term is never read from unwritten locations.

## Timing
- `data_valid` sampled on edge N in IDLE:
  - `busy` is 1 from edge N through edge N+3.
  - `data_out` and `out_valid` update on edge N+3; `out_valid` is high for exactly one cycle.
  - the next sample is accepted on edge N+4 at the earliest; minimum spacing is 4 cycles (1000 cycles at a 50 kHz tick).
- CLEAR lasts exactly `2^ADDR_W` cycles after reset release; the first sample is accepted on the following edge.
- `data_valid` on edge N+3, while `out_valid` is being produced: dropped, and `overrun` is set.
- `out_valid` is never asserted during CLEAR or while `rst_n`=0.

## Test plan
- Reset/clear (ADDR_W=4):
  - release `rst_n` → `busy`=1 for 16 cycles, `data_out`=512, `out_valid`=0.
  - then feed-forward mode, delay=5, 20 samples of 512 → every output is 512 (buffer zeroed).
- Bypass: `data_in`=700 on edge N → `data_out`=700 with `out_valid` on edge N+3, for every `atten`/`delay` setting.
- Feed-forward, delay=3, atten=1: impulse 1023 then 512s → outputs 1023, 512, 512, 767, 512, 512 … (single echo only).
- Feedback, delay=2, atten=1: impulse 1023 then 512s → outputs 1023, 512, 767, 512, 639, 512, 575 … (decaying echoes).
- Saturation, feed-forward, delay=1, atten=0:
  - constant 1023 → outputs settle at 1023 (511+511 clipped to 511).
  - constant 0 → outputs settle at 0 (−1024 clipped to −512).
  - delay wrap: delay=15 with ADDR_W=4 gives the correct echo 15 samples later across the `wr_ptr` wrap.
- Overrun/reset:
  - `data_valid` on edges N and N+2 → one `out_valid` (N+3), `overrun`=1, stays 1.
  - assert `rst_n`=0 at edge N+1 of a sample → no `out_valid`, CLEAR restarts, `overrun`=0.
